ddr_score_keeper: RTL and testbench

Scoring stage downstream of the collision detector and upstream of the seven-segment display. Consumes per-beat hit/miss events plus the game state and maintains:
- the running score,
- the current combo count,
- the best combo,
- the combo-display enable.

The display block renders these values directly. All arithmetic is binary, capped at 9999 to fit four digits.

---
 rtl/ddr_score_keeper_pkg.sv | 20 ++
 rtl/ddr_score_keeper_rise_detect.sv | 19 +
 rtl/ddr_score_keeper.sv | 117 +++++++++++
 tb/tb_ddr_score_keeper.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_score_keeper_pkg.sv
// Shared definitions for the scoring stage: game-state codes, arrow width, saturation limits, window FSM encoding.
package ddr_score_keeper_pkg;

    localparam int STATE_BITS      = 1;
    localparam int NUM_ARROWS_BITS = 2;

    localparam logic [STATE_BITS:0] STATE_RESET    = 2'd0;
    localparam logic [STATE_BITS:0] STATE_PLAY     = 2'd1;
    localparam logic [STATE_BITS:0] STATE_PAUSE    = 2'd2;
    localparam logic [STATE_BITS:0] STATE_GAMEOVER = 2'd3;

    localparam int SCORE_W = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        SCORED = 2'd2
    } win_state_t;

endpackage

// File: rtl/ddr_score_keeper_rise_detect.sv
// Registered rising-edge detector; the delay register samples every cycle so gating elsewhere never fabricates an edge.
// Latency: combinational pulse against a one-cycle-old copy; no backpressure.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_q <= 1'b0;
        else       r_q <= i_d;
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/ddr_score_keeper.sv
// Score / combo / best-combo keeper driven by hit events and beat windows, saturating at SCORE_MAX.
// Latency: outputs registered, update one cycle after the input edge; no backpressure, events accepted every cycle.
module ddr_score_keeper
    import ddr_score_keeper_pkg::*;
#(
    parameter int SCORE_MAX  = 9999,
    parameter int COMBO_STEP = 10,
    parameter int MULT_MAX   = 4,
    parameter int COMBO_SHOW = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [STATE_BITS:0]        state,
    input  logic                       metronome_clk,
    input  logic [NUM_ARROWS_BITS:0]   arrow,
    input  logic                       correctHit,
    input  logic                       incorrectHit,
    output logic [SCORE_W-1:0]         score,
    output logic [SCORE_W-1:0]         comboCount,
    output logic [SCORE_W-1:0]         bestCombo,
    output logic                       combo_en
);

    logic w_beat, w_right, w_wrong;

    rise_detect u_beat  (.clk(clk), .reset(reset), .i_d(metronome_clk), .o_rise(w_beat));
    rise_detect u_right (.clk(clk), .reset(reset), .i_d(correctHit),    .o_rise(w_right));
    rise_detect u_wrong (.clk(clk), .reset(reset), .i_d(incorrectHit),  .o_rise(w_wrong));

    win_state_t r_win, w_next;
    logic w_hit, w_brk, w_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_win <= IDLE;
        else       r_win <= w_next;
    end

    // A hit landing on the closing beat is charged to the old window, and the new one opens ARMED.
    always_comb begin
        w_next = r_win;
        w_hit  = 1'b0;
        w_brk  = 1'b0;
        w_clr  = 1'b0;
        case (state)
            STATE_RESET: begin
                w_clr  = 1'b1;
                w_next = IDLE;
            end
            STATE_PLAY: begin
                case (r_win)
                    IDLE:   if (w_beat) w_next = ARMED;
                    ARMED: begin
                        if (w_wrong) begin
                            w_brk  = 1'b1;
                            w_next = w_beat ? ARMED : SCORED;
                        end else if (w_right) begin
                            w_hit  = 1'b1;
                            w_next = w_beat ? ARMED : SCORED;
                        end else if (w_beat && (arrow != '0)) begin
                            w_brk  = 1'b1;
                        end
                    end
                    SCORED: if (w_beat) w_next = ARMED;
                    default: w_next = IDLE;
                endcase
            end
            STATE_GAMEOVER: w_next = IDLE;
            default: ;
        endcase
    end

    logic [SCORE_W-1:0] r_score, r_combo, r_best;
    logic               r_combo_en;
    logic [SCORE_W-1:0] w_mult, w_score_inc, w_combo_inc, w_best_inc;
    logic [SCORE_W:0]   w_score_sum;

    // Multiplier from the pre-increment combo, clamped once the combo reaches the top step.
    always_comb begin
        if (r_combo >= SCORE_W'((MULT_MAX - 1) * COMBO_STEP))
            w_mult = SCORE_W'(MULT_MAX);
        else
            w_mult = r_combo / SCORE_W'(COMBO_STEP) + SCORE_W'(1);
        w_score_sum = {1'b0, r_score} + {1'b0, w_mult};
        w_score_inc = (w_score_sum >= (SCORE_W + 1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                                : w_score_sum[SCORE_W-1:0];
        w_combo_inc = (r_combo >= SCORE_W'(SCORE_MAX)) ? r_combo : r_combo + SCORE_W'(1);
        w_best_inc  = (w_combo_inc > r_best) ? w_combo_inc : r_best;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score    <= '0;
            r_combo    <= '0;
            r_best     <= '0;
            r_combo_en <= 1'b0;
        end else if (w_clr) begin
            r_score    <= '0;
            r_combo    <= '0;
            r_best     <= '0;
            r_combo_en <= 1'b0;
        end else if (w_brk) begin
            r_combo    <= '0;
            r_combo_en <= 1'b0;
        end else if (w_hit) begin
            r_score    <= w_score_inc;
            r_combo    <= w_combo_inc;
            r_best     <= w_best_inc;
            r_combo_en <= (w_combo_inc >= SCORE_W'(COMBO_SHOW));
        end
    end

    assign score      = r_score;
    assign comboCount = r_combo;
    assign bestCombo  = r_best;
    assign combo_en   = r_combo_en;

endmodule

// File: tb/tb_ddr_score_keeper.sv
// Bench for ddr_score_keeper: directed scenarios plus random play checked every cycle against a rule-level model.
module tb_ddr_score_keeper;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  state;
    logic        metronome_clk;
    logic [2:0]  arrow;
    logic        correctHit;
    logic        incorrectHit;
    logic [13:0] score, comboCount, bestCombo;
    logic        combo_en;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: game rules in plain integer arithmetic.
    int m_score, m_combo, m_best;
    bit m_started, m_used;
    bit p_beat, p_c, p_i;

    always #5 clk = ~clk;

    ddr_score_keeper dut (
        .clk          (clk),
        .reset        (reset),
        .state        (state),
        .metronome_clk(metronome_clk),
        .arrow        (arrow),
        .correctHit   (correctHit),
        .incorrectHit (incorrectHit),
        .score        (score),
        .comboCount   (comboCount),
        .bestCombo    (bestCombo),
        .combo_en     (combo_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".score"}, 32'(score),      m_score);
        check({tag, ".combo"}, 32'(comboCount), m_combo);
        check({tag, ".best"},  32'(bestCombo),  m_best);
        check({tag, ".en"},    32'(combo_en),   (m_combo >= 2) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_score = 0; m_combo = 0; m_best = 0;
        m_started = 0; m_used = 0;
        p_beat = 0; p_c = 0; p_i = 0;
    endtask

    task automatic model_hit();
        int mult;
        mult = m_combo / 10 + 1;
        if (mult > 4) mult = 4;
        m_score = (m_score + mult > 9999) ? 9999 : m_score + mult;
        m_combo = (m_combo + 1 > 9999) ? 9999 : m_combo + 1;
        if (m_combo > m_best) m_best = m_combo;
    endtask

    task automatic model_cycle(input int st, input bit b, input int arr, input bit c, input bit i);
        bit eb, ec, ei;
        eb = b & ~p_beat; ec = c & ~p_c; ei = i & ~p_i;
        p_beat = b; p_c = c; p_i = i;
        case (st)
            0: begin m_score = 0; m_combo = 0; m_best = 0; m_started = 0; m_used = 0; end
            3: m_started = 0;
            1: begin
                if (!m_started) begin
                    if (eb) begin m_started = 1; m_used = 0; end
                end else begin
                    if (!m_used && (ei || ec)) begin
                        if (ei) m_combo = 0;
                        else    model_hit();
                        m_used = 1;
                    end else if (!m_used && eb && arr != 0) begin
                        m_combo = 0;
                    end
                    if (eb) m_used = 0;
                end
            end
            default: ;
        endcase
    endtask

    // Inputs change on the falling edge; outputs are compared on the following falling edge.
    task automatic step(input string tag, input int st, input bit b, input int arr, input bit c, input bit i);
        state = 2'(st); metronome_clk = b; arrow = 3'(arr); correctHit = c; incorrectHit = i;
        @(posedge clk);
        model_cycle(st, b, arr, c, i);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic arm();
        step("arm", 1, 1, 0, 0, 0);
        step("arm", 1, 0, 0, 0, 0);
    endtask

    task automatic fast_hit(input string tag);
        step(tag, 1, 1, 1, 1, 0);
        step(tag, 1, 0, 1, 0, 0);
    endtask

    task automatic clear();
        step("clr", 0, 0, 0, 0, 0);
    endtask

    initial begin
        int sc_before;
        reset = 1'b1;
        state = 2'd0; metronome_clk = 0; arrow = 0; correctHit = 0; incorrectHit = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;

        // Three correct hits in three separate windows.
        arm();
        for (int k = 0; k < 3; k++) begin
            step("s1", 1, 0, 1, 1, 0);
            step("s1", 1, 0, 1, 0, 0);
            step("s1", 1, 1, 1, 0, 0);
            step("s1", 1, 0, 1, 0, 0);
        end
        check("s1_score", 32'(score), 3);
        check("s1_combo", 32'(comboCount), 3);
        check("s1_best",  32'(bestCombo), 3);
        check("s1_en",    32'(combo_en), 1);

        // Correct and incorrect together: incorrect wins; a later correct in the same window is ignored.
        step("simul", 1, 0, 1, 1, 1);
        check("simul_combo", 32'(comboCount), 0);
        check("simul_score", 32'(score), 3);
        step("simul", 1, 0, 1, 0, 0);
        step("simul", 1, 0, 1, 1, 0);
        check("second_hit_score", 32'(score), 3);
        check("second_hit_combo", 32'(comboCount), 0);

        // Multiplier steps.
        clear(); arm();
        for (int k = 0; k < 10; k++) fast_hit("mult");
        check("c10_score", 32'(score), 10);
        fast_hit("mult");
        check("c11_score", 32'(score), 12);
        check("c11_combo", 32'(comboCount), 11);
        for (int k = 0; k < 24; k++) fast_hit("mult");
        check("c35_score", 32'(score), 80);
        fast_hit("mult");
        check("c36_score", 32'(score), 84);

        // Miss: armed window with an arrow and no hit.
        clear(); arm();
        for (int k = 0; k < 5; k++) fast_hit("miss");
        step("miss", 1, 1, 3, 0, 0);
        check("miss_combo", 32'(comboCount), 0);
        check("miss_score", 32'(score), 5);
        check("miss_best",  32'(bestCombo), 5);
        check("miss_en",    32'(combo_en), 0);
        step("miss", 1, 0, 3, 0, 0);

        // Pause swallows the edge; resuming with the level still high scores nothing.
        fast_hit("pre_pause");
        sc_before = m_score;
        step("pause", 2, 0, 1, 1, 0);
        step("pause", 1, 0, 1, 1, 0);
        step("pause", 1, 0, 1, 0, 0);
        check("pause_score", 32'(score), sc_before);

        // Random play.
        for (int k = 0; k < 800; k++) begin
            int r, st;
            r = $urandom_range(0, 31);
            st = (r == 0) ? 0 : (r == 1) ? 3 : (r < 4) ? 2 : 1;
            step("rand", st, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        end

        // Saturation of score.
        clear(); arm();
        while (m_score < 9999) fast_hit("sat");
        check("sat_score", 32'(score), 9999);
        fast_hit("sat_more");
        fast_hit("sat_more");
        check("sat_hold", 32'(score), 9999);

        // Async reset mid-game clears outputs without a clock edge.
        clear(); arm();
        for (int k = 0; k < 4; k++) fast_hit("pre_arst");
        #2 reset = 1'b1;
        #1;
        check("arst_score", 32'(score), 0);
        check("arst_combo", 32'(comboCount), 0);
        check("arst_best",  32'(bestCombo), 0);
        check("arst_en",    32'(combo_en), 0);
        model_reset();
        #1 reset = 1'b0;
        step("post_arst", 1, 0, 1, 1, 0);
        step("post_arst", 1, 0, 1, 0, 0);
        arm();
        fast_hit("post_arst");
        check("post_arst_score", 32'(score), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
